// File: rtl/adder16_if.sv
// Operand/result bundle for the registered 16-bit adder.
// master drives operands and observes results; slave is the adder side.
interface adder16_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        carry_out;
  logic        overflow;
  logic        out_valid;

  modport master (
    output in_valid, a, b,
    input  out, carry_out, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output out, carry_out, overflow, out_valid
  );
endinterface

// File: rtl/adder16.sv
// Registered 16-bit ripple-carry adder with carry/overflow flags; 1-cycle latency, no back-pressure.
// Results and flags hold while in_valid is low; out_valid pulses once per accepted operand pair.
module adder16 (
  input  logic      clk,
  input  logic      rst_n,
  adder16_if.slave  bus
);

  logic [16:0] c;
  logic [15:0] sum;

  assign c[0] = 1'b0;

  // Each cell is two half adders: (a,b) then (partial sum, carry-in).
  for (genvar i = 0; i < 16; i++) begin : g_cell
    logic h1_s, h1_c, h2_c;
    assign h1_s     = bus.a[i] ^ bus.b[i];
    assign h1_c     = bus.a[i] & bus.b[i];
    assign sum[i]   = h1_s ^ c[i];
    assign h2_c     = h1_s & c[i];
    assign c[i+1]   = h1_c | h2_c;
  end

  logic [15:0] out_q,   out_d;
  logic        carry_q, carry_d;
  logic        ovf_q,   ovf_d;
  logic        vld_q,   vld_d;

  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    vld_d   = bus.in_valid;
    if (bus.in_valid) begin
      out_d   = sum;
      carry_d = c[16];
      ovf_d   = c[16] ^ c[15];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 16'h0000;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_adder16.sv
// Randomized and directed bench for adder16 against an arithmetic reference model.
module tb_adder16;

  logic clk = 1'b0;
  logic rst_n;
  adder16_if bus ();

  adder16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit started   = 1'b0;

  // Reference model: plain 17-bit arithmetic and sign rule.
  logic [15:0] m_out = 16'h0;
  logic        m_cy  = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_vld = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 16'h0; m_cy <= 1'b0; m_ovf <= 1'b0; m_vld <= 1'b0;
    end else begin
      m_vld <= bus.in_valid;
      if (bus.in_valid) begin
        int unsigned s;
        s = int'(bus.a) + int'(bus.b);
        m_out <= s[15:0];
        m_cy  <= (s > 32'd65535);
        m_ovf <= (bus.a[15] == bus.b[15]) && (s[15] != bus.a[15]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started)
      chk("model", {13'd0, bus.out_valid, bus.overflow, bus.carry_out, bus.out},
                   {13'd0, m_vld, m_ovf, m_cy, m_out});
  end

  task automatic apply(input logic v, input logic [15:0] x, input logic [15:0] y);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation: {out_valid, overflow, carry_out, out}.
  task automatic lit(input string name, input logic v, input logic o, input logic cy,
                     input logic [15:0] s);
    chk(name, {13'd0, bus.out_valid, bus.overflow, bus.carry_out, bus.out},
              {13'd0, v, o, cy, s});
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h1111;
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    #1;
    lit("reset_hold", 1'b0, 1'b0, 1'b0, 16'h0000);

    rst_n = 1'b1;
    apply(1'b1, 16'd0, 16'd0);          lit("sum_0_0",     1, 0, 0, 16'd0);
    apply(1'b1, 16'd100, 16'd200);      lit("sum_100_200", 1, 0, 0, 16'd300);
    apply(1'b1, 16'd500, 16'd1000);     lit("sum_500_1000",1, 0, 0, 16'd1500);
    apply(1'b1, 16'hFFFF, 16'h0001);    lit("unsigned_wrap", 1, 0, 1, 16'h0000);
    apply(1'b1, 16'h7FFF, 16'h0001);    lit("pos_overflow",  1, 1, 0, 16'h8000);
    apply(1'b1, 16'h8000, 16'h8000);    lit("neg_overflow",  1, 1, 1, 16'h0000);
    apply(1'b1, 16'hFFFF, 16'hFFFF);    lit("neg_no_ovf",    1, 0, 1, 16'hFFFE);

    apply(1'b1, 16'd3, 16'd4);          lit("hold_load",   1, 0, 0, 16'd7);
    apply(1'b0, 16'h00AA, 16'h5500);    lit("hold_1",      0, 0, 0, 16'd7);
    apply(1'b0, 16'hFFFF, 16'h0001);    lit("hold_2",      0, 0, 0, 16'd7);
    apply(1'b0, 16'h7FFF, 16'h7FFF);    lit("hold_3",      0, 0, 0, 16'd7);

    apply(1'b1, 16'd1, 16'd1);          lit("b2b_1",       1, 0, 0, 16'd2);
    apply(1'b1, 16'd2, 16'd2);          lit("b2b_2",       1, 0, 0, 16'd4);
    apply(1'b1, 16'd3, 16'd3);          lit("b2b_3",       1, 0, 0, 16'd6);

    // Mid-cycle asynchronous reset with in_valid still high.
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_reset", 0, 0, 0, 16'h0000);
    @(posedge clk);
    #1;
    lit("reset_ignores_valid", 0, 0, 0, 16'h0000);
    rst_n = 1'b1;
    apply(1'b1, 16'd10, 16'd20);        lit("after_reset", 1, 0, 0, 16'd30);

    for (int i = 0; i < 1000; i++)
      apply(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

    apply(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/adder16.md
# adder16

Registered 16-bit binary adder for the ALU datapath of the from-scratch computer. Sums two 16-bit operands modulo 2^16. Produces unsigned carry-out and signed overflow flags, registered one cycle after the operands are accepted. Adds a clock, an asynchronous active-low reset and a valid qualifier around a structural ripple-carry core.

## Interface
- Parameters: none; width fixed at 16 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  qualifies a and b on the current rising edge.
- a  input  16  first operand, IN1.
- b  input  16  second operand, IN2.
- out  output  16  registered sum (a + b) mod 2^16, OUT.
- carry_out  output  1  registered carry out of bit 15.
- overflow  output  1  registered two's-complement overflow flag.
- out_valid  output  1  high for one cycle when out and flags hold a new result.

## Operation
- Core is combinational ripple-carry: 16 full-adder cells built from half adders.
  - Bit 0 carry-in is 0.
  - Cell i produces sum[i] and c[i+1].
- Sum arithmetic:
  - sum = (a + b) mod 2^16; carry_out = bit 16 of the 17-bit true sum.
  - Operands are treated bit-identically for unsigned and signed use; no saturation.
- overflow = c[16] XOR c[15]. Equivalently, a[15]==b[15] and sum[15]!=a[15].
- Capture:
  - On a rising clk with in_valid=1, out, carry_out and overflow load from the core; out_valid sets to 1.
  - On a rising clk with in_valid=0, out, carry_out and overflow hold their previous values; out_valid clears to 0.
- No back-pressure: every valid operand pair is accepted; consecutive valid cycles produce consecutive results.
- Reset:
  - rst_n=0 immediately forces out=16'h0000, carry_out=0, overflow=0, out_valid=0, independent of clk.
  - Reset mid-stream discards any result not yet presented.
  - First capture after release occurs on the first rising edge with rst_n=1 and in_valid=1.

## Timing
- Latency: exactly 1 cycle from the accepting edge to the result on out.
- Throughput: 1 result per cycle.
- out_valid is asserted in the cycle following each accepting edge and only then.
- Critical path: 16-cell carry chain plus register setup; a and b must be stable before the rising edge.
- Reset assertion is asynchronous. Reset deassertion must be synchronous to clk at system level.
- While rst_n=0, in_valid is ignored.
- No X on outputs after reset, regardless of operand X.

## Test plan
- Reset:
  - Hold rst_n=0 with a=16'h1234, b=16'h1111, in_valid=1 → out=0, carry_out=0, overflow=0, out_valid=0.
  - Assert rst_n low mid-clock while outputs hold a value → outputs clear without waiting for an edge.
- Basic sums, one per cycle: a=0,b=0 → out=0; a=100,b=200 → out=300; a=500,b=1000 → out=1500.
  - For each: carry_out=0, overflow=0, out_valid=1 exactly one cycle after the accepting edge.
- Unsigned wrap: a=16'hFFFF, b=16'h0001 → out=16'h0000, carry_out=1, overflow=0.
- Signed overflow:
  - a=16'h7FFF, b=16'h0001 → out=16'h8000, carry_out=0, overflow=1.
  - a=16'h8000, b=16'h8000 → out=16'h0000, carry_out=1, overflow=1.
- Hold behaviour:
  - Valid pair 3+4, then in_valid=0 for 3 cycles with changing a and b → out stays 7, out_valid high 1 cycle then low.
  - Back-to-back valid pairs 1+1, 2+2, 3+3 → out=2, 4, 6 on consecutive cycles, out_valid continuously high.
- Random: 1000 random pairs with random in_valid → each result matches (a+b)&16'hFFFF and both flags, 1 cycle later.
